// File: rtl/ps2_poly_tone_mapper.sv
// ps2_poly_tone_mapper
//   Decodes a PS/2 Set-2 byte stream (make, F0 break and E0 extended prefixes)
//   into NUM_VOICES polyphonic note slots. It also keeps an octave register
//   that the octave keys move up and down; each slot latches the octave when
//   it is allocated.
//   Optional feature macro: SUSTAIN_PEDAL_EN (scancode 12 acts as a sustain pedal).
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   data        scancode byte from the PS/2 receiver
//   data_valid  one-cycle strobe qualifying data
//   voice_note  slot i at [7i+6:7i], format {octave[2:0], semitone[3:0]}
//   voice_on    per-slot sounding flag
//   octave      current octave register
//   overflow    one-cycle pulse when a make finds every slot busy
module ps2_poly_tone_mapper #(
  parameter int NUM_VOICES  = 4,
  parameter int OCT_DEFAULT = 3,
  parameter int OCT_MAX     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              data,
  input  logic                    data_valid,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]   voice_on,
  output logic [2:0]              octave,
  output logic                    overflow
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BRK     = 2'd1;
  localparam logic [1:0] EXT     = 2'd2;
  localparam logic [1:0] EXT_BRK = 2'd3;

  localparam logic [2:0] OCT_RST = 3'(OCT_DEFAULT);
  localparam logic [2:0] OCT_TOP = 3'(OCT_MAX);

  logic [1:0]                  fsm_q, fsm_d;
  logic [NUM_VOICES-1:0]       on_q, on_d;
  logic [NUM_VOICES-1:0][6:0]  note_q, note_d;
  logic [NUM_VOICES-1:0][3:0]  tag_q, tag_d;
  logic [2:0]                  oct_q, oct_d;
  logic                        ovf_d;
  logic [4:0]                  map;
  logic                        dup, free_found;
`ifdef SUSTAIN_PEDAL_EN
  logic                        sus_q, sus_d;
  logic [NUM_VOICES-1:0]       rel_q, rel_d;
`endif

  // {hit, semitone} for the twelve note keys.
  function automatic logic [4:0] semi_map(input logic [7:0] b);
    case (b)
      8'h1C:   semi_map = {1'b1, 4'd0};
      8'h1D:   semi_map = {1'b1, 4'd1};
      8'h1B:   semi_map = {1'b1, 4'd2};
      8'h24:   semi_map = {1'b1, 4'd3};
      8'h23:   semi_map = {1'b1, 4'd4};
      8'h2B:   semi_map = {1'b1, 4'd5};
      8'h2C:   semi_map = {1'b1, 4'd6};
      8'h34:   semi_map = {1'b1, 4'd7};
      8'h35:   semi_map = {1'b1, 4'd8};
      8'h33:   semi_map = {1'b1, 4'd9};
      8'h3C:   semi_map = {1'b1, 4'd10};
      8'h3B:   semi_map = {1'b1, 4'd11};
      default: semi_map = 5'd0;
    endcase
  endfunction

  always_comb begin
    fsm_d      = fsm_q;
    on_d       = on_q;
    note_d     = note_q;
    tag_d      = tag_q;
    oct_d      = oct_q;
    ovf_d      = 1'b0;
`ifdef SUSTAIN_PEDAL_EN
    sus_d      = sus_q;
    rel_d      = rel_q;
`endif
    map        = semi_map(data);
    dup        = 1'b0;
    free_found = 1'b0;
    if (data_valid) begin
      case (fsm_q)
        IDLE: begin
          if (data == 8'hF0) begin
            fsm_d = BRK;
          end else if (data == 8'hE0) begin
            fsm_d = EXT;
          end else if (map[4]) begin
            // A sounding slot with the same tag absorbs the make (typematic
            // repeat, or re-arming a released slot under sustain).
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
              if (on_q[i] && tag_q[i] == map[3:0]) begin
                dup = 1'b1;
`ifdef SUSTAIN_PEDAL_EN
                rel_d[i] = 1'b0;
`endif
              end
            end
            if (!dup) begin
              for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (!free_found && !on_q[i]) begin
                  free_found = 1'b1;
                  on_d[i]    = 1'b1;
                  note_d[i]  = {oct_q, map[3:0]};
                  tag_d[i]   = map[3:0];
                end
              end
              if (!free_found) ovf_d = 1'b1;
            end
          end else if (data == 8'h1A) begin
            if (oct_q != 3'd0) oct_d = oct_q - 3'd1;
          end else if (data == 8'h22) begin
            if (oct_q < OCT_TOP) oct_d = oct_q + 3'd1;
          end else if (data == 8'h29) begin
            on_d = '0;
`ifdef SUSTAIN_PEDAL_EN
            rel_d = '0;
          end else if (data == 8'h12) begin
            sus_d = 1'b1;
`endif
          end
        end
        BRK: begin
          fsm_d = IDLE;
          if (map[4]) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
              if (on_q[i] && tag_q[i] == map[3:0]) begin
`ifdef SUSTAIN_PEDAL_EN
                if (sus_q) rel_d[i] = 1'b1;
                else       on_d[i]  = 1'b0;
`else
                on_d[i] = 1'b0;
`endif
              end
            end
`ifdef SUSTAIN_PEDAL_EN
          end else if (data == 8'h12) begin
            sus_d = 1'b0;
            on_d  = on_q & ~rel_q;
            rel_d = '0;
`endif
          end
        end
        EXT:     fsm_d = (data == 8'hF0) ? EXT_BRK : IDLE;
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= IDLE;
      on_q     <= '0;
      note_q   <= '0;
      tag_q    <= '0;
      oct_q    <= OCT_RST;
      overflow <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
      sus_q    <= 1'b0;
      rel_q    <= '0;
`endif
    end else begin
      fsm_q    <= fsm_d;
      on_q     <= on_d;
      note_q   <= note_d;
      tag_q    <= tag_d;
      oct_q    <= oct_d;
      overflow <= ovf_d;
`ifdef SUSTAIN_PEDAL_EN
      sus_q    <= sus_d;
      rel_q    <= rel_d;
`endif
    end
  end

  assign voice_note = note_q;
  assign voice_on   = on_q;
  assign octave     = oct_q;

endmodule

// File: tb/tb_ps2_poly_tone_mapper.sv
// tb_ps2_poly_tone_mapper
//   Scoreboard bench: each byte sent pushes the reference model's expected
//   outputs; a monitor pops and compares one cycle after acceptance and checks
//   that outputs hold (overflow low) on all other cycles.
module tb_ps2_poly_tone_mapper;
  localparam int NV = 4;
  localparam int OMAX = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      data = 8'h00;
  logic            data_valid = 1'b0;
  logic [7*NV-1:0] voice_note;
  logic [NV-1:0]   voice_on;
  logic [2:0]      octave;
  logic            overflow;

  ps2_poly_tone_mapper #(.NUM_VOICES(NV), .OCT_DEFAULT(3), .OCT_MAX(OMAX)) dut (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
    .voice_note(voice_note), .voice_on(voice_on), .octave(octave), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NV-1:0]   on;
    logic [7*NV-1:0] note;
    logic [2:0]      oct;
    logic            ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: key-level view of the keyboard.
  int  m_on[NV], m_note[NV], m_tag[NV], m_rel[NV];
  int  m_oct, m_ovf, m_sus;
  bit  m_after_f0, m_after_e0;
  byte unsigned note_keys[12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                  8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};
  bit  sustain_built;

  function automatic int semitone_of(input byte unsigned b);
    for (int k = 0; k < 12; k++) if (note_keys[k] == b) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_on[i] = 0; m_note[i] = 0; m_tag[i] = 0; m_rel[i] = 0;
    end
    m_oct = 3; m_ovf = 0; m_sus = 0; m_after_f0 = 0; m_after_e0 = 0;
  endtask

  task automatic key_down(input byte unsigned b);
    int s, slot;
    s = semitone_of(b);
    if (s >= 0) begin
      slot = -1;
      for (int i = 0; i < NV; i++) if (m_on[i] != 0 && m_tag[i] == s) slot = i;
      if (slot >= 0) begin
        m_rel[slot] = 0;
      end else begin
        for (int i = NV - 1; i >= 0; i--) if (m_on[i] == 0) slot = i;
        if (slot < 0) m_ovf = 1;
        else begin
          m_on[slot] = 1; m_tag[slot] = s; m_rel[slot] = 0;
          m_note[slot] = m_oct * 16 + s;
        end
      end
    end else if (b == 8'h1A) begin
      if (m_oct > 0) m_oct--;
    end else if (b == 8'h22) begin
      if (m_oct < OMAX) m_oct++;
    end else if (b == 8'h29) begin
      for (int i = 0; i < NV; i++) begin m_on[i] = 0; m_rel[i] = 0; end
    end else if (b == 8'h12 && sustain_built) begin
      m_sus = 1;
    end
  endtask

  task automatic key_up(input byte unsigned b);
    int s;
    s = semitone_of(b);
    if (s >= 0) begin
      for (int i = 0; i < NV; i++)
        if (m_on[i] != 0 && m_tag[i] == s) begin
          if (m_sus != 0) m_rel[i] = 1; else m_on[i] = 0;
        end
    end else if (b == 8'h12 && sustain_built) begin
      m_sus = 0;
      for (int i = 0; i < NV; i++) if (m_rel[i] != 0) begin m_on[i] = 0; m_rel[i] = 0; end
    end
  endtask

  task automatic model_byte(input byte unsigned b);
    m_ovf = 0;
    if (m_after_e0) begin
      // Extended key: swallow optional F0 plus the code byte.
      if (!m_after_f0 && b == 8'hF0) m_after_f0 = 1;
      else begin m_after_e0 = 0; m_after_f0 = 0; end
    end else if (m_after_f0) begin
      key_up(b);
      m_after_f0 = 0;
    end else if (b == 8'hF0) m_after_f0 = 1;
    else if (b == 8'hE0) m_after_e0 = 1;
    else key_down(b);
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < NV; i++) begin
      e.on[i] = (m_on[i] != 0);
      e.note[7*i +: 7] = 7'(m_note[i]);
    end
    e.oct = 3'(m_oct);
    e.ovf = (m_ovf != 0);
    return e;
  endfunction

  // Driver tasks are entered and left 1 time unit after a rising edge.
  task automatic send(input byte unsigned b, input int idle);
    data = b; data_valid = 1'b1;
    model_byte(b);
    exp_q.push_back(model_out());
    @(posedge clk); #1;
    data_valid = 1'b0; data = 8'($urandom);
    repeat (idle) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor
  logic vq = 1'b0;
  exp_t mexp;
  always @(posedge clk) vq <= data_valid && !rst;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mexp = '0;
      mexp.oct = 3'd3;
    end else if (vq) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        mexp = exp_q.pop_front();
      end
    end else begin
      mexp.ovf = 1'b0;
    end
    chk("voice_on", 32'(voice_on), 32'(mexp.on));
    chk("voice_note", 32'(voice_note), 32'(mexp.note));
    chk("octave", 32'(octave), 32'(mexp.oct));
    chk("overflow", 32'(overflow), 32'(mexp.ovf));
  end

  byte unsigned pool[16] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h3B, 8'h1D, 8'h35,
                             8'hF0, 8'hF0, 8'hE0, 8'h1A, 8'h22, 8'h29, 8'h12, 8'h00};

  initial begin
`ifdef SUSTAIN_PEDAL_EN
    sustain_built = 1;
`else
    sustain_built = 0;
`endif
    model_reset();
    @(posedge clk); #1;
    do_reset();
    chk("rst_voice_on", 32'(voice_on), 32'h0);
    chk("rst_octave", 32'(octave), 32'd3);

    send(8'h1C, 0);
    chk("first_note_on", 32'(voice_on), 32'h1);
    chk("first_note", 32'(voice_note[6:0]), 32'h30);
    send(8'hF0, 0); send(8'h1C, 0);
    chk("break_off", 32'(voice_on), 32'h0);
    chk("break_note_kept", 32'(voice_note[6:0]), 32'h30);
    send(8'h1C, 0); send(8'h1C, 0); send(8'h1C, 0);
    chk("typematic", 32'(voice_on), 32'h1);
    send(8'h1B, 1);
    chk("second_slot_note", 32'(voice_note[13:7]), 32'h32);
    chk("second_slot_on", 32'(voice_on), 32'h3);

    do_reset();
    send(8'h1C, 0); send(8'h1B, 0); send(8'h23, 0); send(8'h2B, 0); send(8'h34, 0);
    chk("overflow_pulse", 32'(overflow), 32'h1);
    chk("full_on", 32'(voice_on), 32'hF);
    @(posedge clk); #1;
    chk("overflow_one_cycle", 32'(overflow), 32'h0);

    do_reset();
    repeat (5) send(8'h22, 0);
    chk("octave_sat_hi", 32'(octave), 32'd6);
    send(8'h1C, 0);
    chk("note_oct6", 32'(voice_note[6:0]), 32'h60);
    repeat (8) send(8'h1A, 0);
    chk("octave_sat_lo", 32'(octave), 32'd0);
    chk("note_latched", 32'(voice_note[6:0]), 32'h60);

    do_reset();
    send(8'hE0, 0); send(8'h1C, 0);
    chk("ext_make_ignored", 32'(voice_on), 32'h0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h1C, 0);
    chk("ext_break_ignored", 32'(voice_on), 32'h0);
    send(8'h1C, 0); send(8'h1B, 0); send(8'h23, 0); send(8'h29, 0);
    chk("space_all_off", 32'(voice_on), 32'h0);
    send(8'hF0, 0);
    do_reset();
    send(8'h1C, 0);
    chk("reset_drops_prefix", 32'(voice_on), 32'h1);

`ifdef SUSTAIN_PEDAL_EN
    do_reset();
    send(8'h12, 0); send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
    chk("sustain_hold", 32'(voice_on), 32'h1);
    send(8'hF0, 0); send(8'h12, 0);
    chk("sustain_release", 32'(voice_on), 32'h0);
`endif

    do_reset();
    for (int n = 0; n < 800; n++) begin
      byte unsigned b;
      b = ($urandom_range(0, 19) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
      send(b, ($urandom_range(0, 3) == 0) ? 1 : 0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
